// File: rtl/ccm_pkg.sv
// ccm_pkg: shared definitions for the CCM receive-side counter-mode decryptor.
//   - default field widths of the counter block A_i = {flag, nonce, i}
//   - FSM state encoding (IDLE/KS/DATA/TAG_KS/TAG)
//   - ctr_block(): builds A_i
//   - ks_byte():   extracts keystream byte idx, MSB first
package ccm_pkg;

  localparam int CCM_WIDTH_FLAG  = 8;
  localparam int CCM_WIDTH_NONCE = 100;
  localparam int CCM_WIDTH_COUNT = 20;
  localparam int CCM_WIDTH_KEY   = CCM_WIDTH_FLAG + CCM_WIDTH_NONCE + CCM_WIDTH_COUNT;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_KS     = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_TAG_KS = 3'd3;
  localparam logic [2:0] ST_TAG    = 3'd4;

  function automatic logic [CCM_WIDTH_KEY-1:0] ctr_block(
    input logic [CCM_WIDTH_FLAG-1:0]  flag,
    input logic [CCM_WIDTH_NONCE-1:0] nonce,
    input logic [CCM_WIDTH_COUNT-1:0] i
  );
    return {flag, nonce, i};
  endfunction

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] ks_byte(
    input logic [CCM_WIDTH_KEY-1:0] block,
    input logic [3:0]               idx
  );
    logic [CCM_WIDTH_KEY-1:0] w_shifted;
    w_shifted = block << {idx, 3'b000};
    return w_shifted[CCM_WIDTH_KEY-1 -: 8];
  endfunction

endpackage

// File: rtl/ccm_keystream_gen.sv
// ccm_keystream_gen: owns the block counter and the keystream register.
//   clk, reset     clock, asynchronous active-low reset
//   i_ctr_init     set counter to 1 (start of a frame with payload)
//   i_ctr_inc      advance counter to the next payload block
//   i_load         ks <= A_ctr ^ key
//   i_load_zero    ks <= A_0 ^ key (MIC keystream)
//   i_flag/i_nonce counter block fields, latched by the caller
//   i_key          AES key stand-in, static for the frame
//   o_ks           registered keystream block
module ccm_keystream_gen
  import ccm_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_ctr_init,
  input  logic                       i_ctr_inc,
  input  logic                       i_load,
  input  logic                       i_load_zero,
  input  logic [CCM_WIDTH_FLAG-1:0]  i_flag,
  input  logic [CCM_WIDTH_NONCE-1:0] i_nonce,
  input  logic [CCM_WIDTH_KEY-1:0]   i_key,
  output logic [CCM_WIDTH_KEY-1:0]   o_ks
);

  logic [CCM_WIDTH_COUNT-1:0] r_ctr;
  logic [CCM_WIDTH_KEY-1:0]   r_ks;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctr <= '0;
      r_ks  <= '0;
    end else begin
      if (i_ctr_init)
        r_ctr <= CCM_WIDTH_COUNT'(1);
      else if (i_ctr_inc)
        r_ctr <= r_ctr + CCM_WIDTH_COUNT'(1);

      if (i_load)
        r_ks <= ctr_block(i_flag, i_nonce, r_ctr) ^ i_key;
      else if (i_load_zero)
        r_ks <= ctr_block(i_flag, i_nonce, '0) ^ i_key;
    end
  end

  assign o_ks = r_ks;

endmodule

// File: rtl/ccm_ctr_dec.sv
// ccm_ctr_dec: receive-side CCM counter-mode decryptor.
// Decrypts a byte-serial frame: payload bytes use S_1, S_2, ...; the trailing
// MIC bytes use S_0 and are collected into tag_data (first byte in the MSBs).
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   frame_start, payload_length, ctr_nonce, ctr_flag   frame setup (IDLE only)
//   key_aes                    key, static for the frame
//   in_data/in_valid/in_ready  ciphertext stream in
//   out_data/out_valid/out_ready plaintext stream out
//   tag_data/tag_valid         recovered MIC, 1-cycle valid pulse
//   busy                       frame in progress
// Optional feature macro CCM_TAG_CHECK_EN: adds mic_ref input and tag_ok output
// (tag_ok = tag_valid && tag_data == mic_ref).
module ccm_ctr_dec
  import ccm_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int WIDTH_NONCE = CCM_WIDTH_NONCE,
  parameter  int WIDTH_FLAG  = CCM_WIDTH_FLAG,
  parameter  int WIDTH_COUNT = CCM_WIDTH_COUNT,
  parameter  int WIDTH_LEN   = 16,
  parameter  int TAG_BYTES   = 8,
  localparam int WIDTH_KEY   = WIDTH_NONCE + WIDTH_FLAG + WIDTH_COUNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic [WIDTH_LEN-1:0]   payload_length,
  input  logic [WIDTH_NONCE-1:0] ctr_nonce,
  input  logic [WIDTH_FLAG-1:0]  ctr_flag,
  input  logic [WIDTH_KEY-1:0]   key_aes,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_BYTES*8-1:0] tag_data,
  output logic                   tag_valid,
  output logic                   busy
`ifdef CCM_TAG_CHECK_EN
  ,
  input  logic [TAG_BYTES*8-1:0] mic_ref,
  output logic                   tag_ok
`endif
);

  localparam int TAG_W = TAG_BYTES * 8;
  // Largest block count the counter can reach without wrapping.
  localparam logic [63:0] MAX_BLOCKS = (64'd1 << WIDTH_COUNT) - 64'd1;

  logic [2:0]             r_state;
  logic [WIDTH_LEN-1:0]   r_len_rem;
  logic [3:0]             r_byte_idx;
  logic [WIDTH_FLAG-1:0]  r_flag;
  logic [WIDTH_NONCE-1:0] r_nonce;
  logic [WIDTH-1:0]       r_out_data;
  logic                   r_out_valid;
  logic [TAG_W-1:0]       r_tag_data;
  logic                   r_tag_valid;

  logic [WIDTH_KEY-1:0]   w_ks;
  logic [7:0]             w_ks_byte;
  logic [63:0]            w_blocks;
  logic                   w_in_ready;
  logic                   w_in_fire;
  logic                   w_start;
  logic                   w_last_payload;
  logic                   w_ctr_inc;

  assign w_blocks       = (64'(payload_length) + 64'd15) >> 4;
  assign w_ks_byte      = ks_byte(w_ks, r_byte_idx);
  assign w_last_payload = (r_len_rem == WIDTH_LEN'(1));

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned (which would infer a latch).
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_DATA: w_in_ready = !r_out_valid || out_ready;
      ST_TAG:  w_in_ready = 1'b1;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_in_fire = in_valid && w_in_ready;
  assign w_start   = (r_state == ST_IDLE) && frame_start && (w_blocks <= MAX_BLOCKS);
  assign w_ctr_inc = (r_state == ST_DATA) && w_in_fire && !w_last_payload &&
                     (r_byte_idx == 4'd15);

  ccm_keystream_gen u_ks (
    .clk         (clk),
    .reset       (reset),
    .i_ctr_init  (w_start),
    .i_ctr_inc   (w_ctr_inc),
    .i_load      (r_state == ST_KS),
    .i_load_zero (r_state == ST_TAG_KS),
    .i_flag      (r_flag),
    .i_nonce     (r_nonce),
    .i_key       (key_aes),
    .o_ks        (w_ks)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_len_rem   <= '0;
      r_byte_idx  <= '0;
      r_flag      <= '0;
      r_nonce     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_tag_data  <= '0;
      r_tag_valid <= 1'b0;
    end else begin
      r_tag_valid <= 1'b0;
      // A pending plaintext byte drains in any state; a new transfer below wins.
      if (out_ready)
        r_out_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_len_rem  <= payload_length;
            r_flag     <= ctr_flag;
            r_nonce    <= ctr_nonce;
            r_tag_data <= '0;
            r_state    <= (payload_length != '0) ? ST_KS : ST_TAG_KS;
          end
        end
        ST_KS: begin
          r_byte_idx <= '0;
          r_state    <= ST_DATA;
        end
        ST_DATA: begin
          if (w_in_fire) begin
            r_out_data  <= in_data ^ w_ks_byte;
            r_out_valid <= 1'b1;
            r_len_rem   <= r_len_rem - WIDTH_LEN'(1);
            r_byte_idx  <= r_byte_idx + 4'd1;
            if (w_last_payload)
              r_state <= ST_TAG_KS;
            else if (r_byte_idx == 4'd15)
              r_state <= ST_KS;
          end
        end
        ST_TAG_KS: begin
          r_byte_idx <= '0;
          r_state    <= ST_TAG;
        end
        ST_TAG: begin
          if (w_in_fire) begin
            r_tag_data <= (r_tag_data << 8) | TAG_W'(in_data ^ w_ks_byte);
            r_byte_idx <= r_byte_idx + 4'd1;
            if (r_byte_idx == 4'(TAG_BYTES - 1)) begin
              r_tag_valid <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign tag_data  = r_tag_data;
  assign tag_valid = r_tag_valid;
  assign busy      = (r_state != ST_IDLE);

`ifdef CCM_TAG_CHECK_EN
  assign tag_ok = r_tag_valid && (r_tag_data == mic_ref);
`else
  // No MIC comparison in this build.
`endif

endmodule

// File: tb/tb_ccm_ctr_dec.sv
// Directed self-checking bench for ccm_ctr_dec (default parameters).
module tb_ccm_ctr_dec;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         frame_start = 1'b0;
  logic [15:0]  payload_length = '0;
  logic [99:0]  ctr_nonce = '0;
  logic [7:0]   ctr_flag = 8'h01;
  logic [127:0] key_aes = '0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [63:0]  tag_data;
  logic         tag_valid;
  logic         busy;
`ifdef CCM_TAG_CHECK_EN
  logic [63:0]  mic_ref = '0;
  logic         tag_ok;
`endif

  always #5 clk = ~clk;

  ccm_ctr_dec dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .payload_length (payload_length),
    .ctr_nonce      (ctr_nonce),
    .ctr_flag       (ctr_flag),
    .key_aes        (key_aes),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .tag_data       (tag_data),
    .tag_valid      (tag_valid),
    .busy           (busy)
`ifdef CCM_TAG_CHECK_EN
    ,
    .mic_ref        (mic_ref),
    .tag_ok         (tag_ok)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Capture of plaintext transfers and tag pulses, sampled on the falling edge.
  logic [7:0]  rx [0:511];
  int          rx_n = 0;
  int          tag_cnt = 0;
  logic [63:0] tag_last = '0;

  always @(negedge clk) begin
    if (out_valid && out_ready && rx_n < 512) begin
      rx[rx_n] <= out_data;
      rx_n     <= rx_n + 1;
    end
    if (tag_valid) begin
      tag_cnt  <= tag_cnt + 1;
      tag_last <= tag_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the transfer.
  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("push_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] len);
    payload_length = len;
    frame_start    = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic push_tag(input logic [7:0] b);
    for (int k = 0; k < 8; k++) push_byte(b);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  int          base;
  int          tag0;
  logic [7:0]  exp_b;
  logic [7:0]  key_exp [0:15];

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_tag_valid", 64'(tag_valid), 64'd0);
    chk("rst_tag_data",  tag_data,       64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // ---------------- T1: len=16, zero key/nonce ----------------
    base = rx_n;
    tag0 = tag_cnt;
    start_frame(16);
    chk("t1_busy_ks",     64'(busy),     64'd1);
    chk("t1_in_ready_ks", 64'(in_ready), 64'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        // frame_start while busy must be ignored
        payload_length = 16'd1;
        frame_start    = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
      end
      push_byte(8'h00);
    end
    push_tag(8'hAA);
    chk("t1_tag_valid", 64'(tag_valid), 64'd1);
    // T2 starts in the tag_valid cycle
    start_frame(17);
    chk("t2_accept_on_tag_valid", 64'(busy), 64'd1);
    chk("t1_count", 64'(rx_n - base), 64'd16);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i == 0 || i == 15) ? 8'h01 : 8'h00;
      chk($sformatf("t1_byte%0d", i), 64'(rx[base + i]), 64'(exp_b));
    end
    chk("t1_tag_pulses", 64'(tag_cnt - tag0), 64'd1);
    chk("t1_tag_data",   tag_last,            64'hABAAAAAAAAAAAAAA);

    // ---------------- T2: len=17 ----------------
    base = rx_n;
    tag0 = tag_cnt;
    for (int i = 0; i < 17; i++) push_byte(8'h00);
    push_tag(8'hAA);
    settle();
    chk("t2_count",  64'(rx_n - base),   64'd17);
    chk("t2_byte0",  64'(rx[base + 0]),  64'h01);
    chk("t2_byte14", 64'(rx[base + 14]), 64'h00);
    chk("t2_byte15", 64'(rx[base + 15]), 64'h01);
    chk("t2_byte16", 64'(rx[base + 16]), 64'h01);
    chk("t2_tag",    tag_last,           64'hABAAAAAAAAAAAAAA);
    chk("t2_busy",   64'(busy),          64'd0);

    // ---------------- T2b: len=32, second block uses counter 2 ----------------
    base = rx_n;
    start_frame(32);
    for (int i = 0; i < 32; i++) push_byte(8'h00);
    push_tag(8'hAA);
    settle();
    chk("t2b_count",  64'(rx_n - base),   64'd32);
    chk("t2b_byte15", 64'(rx[base + 15]), 64'h01);
    chk("t2b_byte16", 64'(rx[base + 16]), 64'h01);
    chk("t2b_byte30", 64'(rx[base + 30]), 64'h00);
    chk("t2b_byte31", 64'(rx[base + 31]), 64'h02);

    // ---------------- nonzero key and nonce ----------------
    // key byte i = i*0x11; A_1 bytes: [0]=01, [13]=10 (nonce bit 0), [15]=01
    key_aes   = 128'h00112233445566778899AABBCCDDEEFF;
    ctr_nonce = 100'h1;
    key_exp = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCD, 8'hEE, 8'hFE};
    base = rx_n;
    start_frame(16);
    for (int i = 0; i < 16; i++) push_byte(8'h00);
    push_tag(8'h00);
    settle();
    for (int i = 0; i < 16; i++)
      chk($sformatf("key_byte%0d", i), 64'(rx[base + i]), 64'(key_exp[i]));
    chk("key_tag", tag_last, 64'h0111223344556677);
    key_aes   = '0;
    ctr_nonce = '0;

    // ---------------- T3: len=0 ----------------
    base = rx_n;
    tag0 = tag_cnt;
    start_frame(0);
    chk("t3_busy", 64'(busy), 64'd1);
    push_tag(8'hAA);
    settle();
    chk("t3_no_out",     64'(rx_n - base),    64'd0);
    chk("t3_tag_pulses", 64'(tag_cnt - tag0), 64'd1);
    chk("t3_tag",        tag_last,            64'hABAAAAAAAAAAAAAA);

    // ---------------- T4: back-pressure mid-payload ----------------
    base = rx_n;
    start_frame(16);
    for (int i = 0; i < 5; i++) push_byte(8'(i));
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("t4_stall%0d_in_ready", c),  64'(in_ready),  64'd0);
      chk($sformatf("t4_stall%0d_out_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("t4_stall%0d_out_data", c),  64'(out_data),  64'h04);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 5; i < 16; i++) push_byte(8'(i));
    push_tag(8'hAA);
    settle();
    chk("t4_count", 64'(rx_n - base), 64'd16);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i == 0) ? 8'h01 : (i == 15) ? 8'h0E : 8'(i);
      chk($sformatf("t4_byte%0d", i), 64'(rx[base + i]), 64'(exp_b));
    end

    // ---------------- T5: reset mid-frame ----------------
    tag0 = tag_cnt;
    start_frame(16);
    for (int i = 0; i < 8; i++) push_byte(8'h00);
    reset = 1'b0;
    #1;
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_out_data",  64'(out_data),  64'd0);
    chk("t5_busy",      64'(busy),      64'd0);
    chk("t5_in_ready",  64'(in_ready),  64'd0);
    chk("t5_tag_valid", 64'(tag_valid), 64'd0);
    chk("t5_tag_data",  tag_data,       64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_no_tag", 64'(tag_cnt - tag0), 64'd0);
    base = rx_n;
    start_frame(16);
    for (int i = 0; i < 16; i++) push_byte(8'h00);
    push_tag(8'hAA);
    settle();
    chk("t5_count",  64'(rx_n - base),   64'd16);
    chk("t5_byte0",  64'(rx[base + 0]),  64'h01);
    chk("t5_byte7",  64'(rx[base + 7]),  64'h00);
    chk("t5_byte15", 64'(rx[base + 15]), 64'h01);
    chk("t5_tag",    tag_last,           64'hABAAAAAAAAAAAAAA);

`ifdef CCM_TAG_CHECK_EN
    // ---------------- T6: MIC compare ----------------
    mic_ref = 64'hABAAAAAAAAAAAAAA;
    start_frame(0);
    push_tag(8'hAA);
    chk("t6_tag_ok_match", 64'(tag_ok), 64'd1);
    @(posedge clk);
    #1;
    chk("t6_tag_ok_idle", 64'(tag_ok), 64'd0);
    mic_ref = 64'hABAAAAAAAAAAAAAB;
    start_frame(0);
    push_tag(8'hAA);
    chk("t6_tag_valid",   64'(tag_valid), 64'd1);
    chk("t6_tag_ok_flip", 64'(tag_ok),    64'd0);
    settle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
